// File: rtl/mix_shift_seq.sv
// Sequential MIX shift unit: byte shifts/rotates and binary shifts on rA/rX magnitudes,
// one unit per clock, with start/busy/done handshake and clamped shift count.
module mix_shift_seq #(
  parameter int unsigned BYTE_BITS = 6,
  parameter int unsigned NBYTES    = 5,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned BINARY_EN = 1,
  localparam int unsigned W        = BYTE_BITS * NBYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       field,
  input  logic [CNT_W-1:0] m,
  input  logic [W-1:0]     ina,
  input  logic [W-1:0]     inx,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [W-1:0]     outa,
  output logic [W-1:0]     outx,
  output logic [2*W-1:0]   out
);

  localparam int unsigned W2 = 2 * W;
  localparam int unsigned KW = $clog2(W2 + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [2:0]      op;
  logic            err_pend;
  logic [KW-1:0]   cnt;
  logic [W-1:0]    wa;
  logic [W-1:0]    wx;
  logic [W2-1:0]   ax;
  logic [W2-1:0]   shift_c;
  logic [31:0]     m32;
  logic [31:0]     k_c;
  logic            invalid_c;

  assign ax  = {wa, wx};
  assign m32 = 32'(m);
  assign out = {outa, outx};

  // Effective count: byte shifts clamp, rotates wrap, binary shifts clamp to 2W.
  always_comb begin
    k_c       = '0;
    invalid_c = 1'b0;
    case (field)
      4'd0, 4'd1: k_c = (m32 > NBYTES) ? NBYTES : m32;
      4'd2, 4'd3: k_c = (m32 > 2 * NBYTES) ? 2 * NBYTES : m32;
      4'd4, 4'd5: k_c = m32 % (2 * NBYTES);
      4'd6, 4'd7: begin
        if (BINARY_EN != 0) k_c = (m32 > W2) ? W2 : m32;
        else                invalid_c = 1'b1;
      end
      default:    invalid_c = 1'b1;
    endcase
  end

  // One step of the captured operation on the work registers.
  always_comb begin
    shift_c = ax;
    case (op)
      3'd0: shift_c = {wa << BYTE_BITS, wx};
      3'd1: shift_c = {wa >> BYTE_BITS, wx};
      3'd2: shift_c = ax << BYTE_BITS;
      3'd3: shift_c = ax >> BYTE_BITS;
      3'd4: shift_c = {ax[W2-BYTE_BITS-1:0], ax[W2-1:W2-BYTE_BITS]};
      3'd5: shift_c = {ax[BYTE_BITS-1:0], ax[W2-1:BYTE_BITS]};
      3'd6: shift_c = ax << 1;
      3'd7: shift_c = ax >> 1;
      default: shift_c = ax;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op       <= '0;
      err_pend <= 1'b0;
      cnt      <= '0;
      wa       <= '0;
      wx       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      outa     <= '0;
      outx     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wa       <= ina;
            wx       <= inx;
            op       <= field[2:0];
            err_pend <= invalid_c;
            cnt      <= invalid_c ? '0 : KW'(k_c);
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            outa  <= wa;
            outx  <= wx;
            done  <= 1'b1;
            err   <= err_pend;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            {wa, wx} <= shift_c;
            cnt      <= cnt - KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_shift_seq.sv
// Directed self-checking bench for mix_shift_seq with default parameters.
module tb_mix_shift_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  field;
  logic [11:0] m;
  logic [29:0] ina, inx;
  logic        busy, done, err;
  logic [29:0] outa, outx;
  logic [59:0] out;

  int total = 0;
  int bad   = 0;

  localparam logic [29:0] A0 = {6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
  localparam logic [29:0] X0 = {6'd6, 6'd7, 6'd8, 6'd9, 6'd10};

  mix_shift_seq dut (
    .clk(clk), .reset(reset), .start(start), .field(field), .m(m),
    .ina(ina), .inx(inx), .busy(busy), .done(done), .err(err),
    .outa(outa), .outx(outx), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, then measure latency and check the results.
  task automatic run(input string tag, input logic [3:0] f, input logic [11:0] mm,
                     input logic [29:0] a, input logic [29:0] x,
                     input logic [29:0] ea, input logic [29:0] ex,
                     input int lat, input logic eerr);
    int n;
    bit got;
    @(negedge clk);
    field = f; m = mm; ina = a; inx = x; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ina = '1; inx = '1; field = 4'd0; m = 12'd1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0; got = 0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_a"}, 64'(outa), 64'(ea));
    chk({tag, "_x"}, 64'(outx), 64'(ex));
    chk({tag, "_out"}, 64'(out), 64'({ea, ex}));
    chk({tag, "_err"}, 64'(err), 64'(eerr));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'({done, err}), 64'd0);
  endtask

  initial begin
    int n_done;
    reset = 1'b1; start = 1'b0; field = '0; m = '0; ina = '0; inx = '0;
    #2;
    chk("reset_state", 64'({busy, done, err, outa, outx}), 64'd0);
    @(negedge clk); reset = 1'b0;

    run("sla2",   4'd0, 12'd2,    A0, X0, {6'd3, 6'd4, 6'd5, 6'd0, 6'd0}, X0, 3, 1'b0);
    run("srax3",  4'd3, 12'd3,    A0, X0, {6'd0, 6'd0, 6'd0, 6'd1, 6'd2},
        {6'd3, 6'd4, 6'd5, 6'd6, 6'd7}, 4, 1'b0);
    run("slc13",  4'd4, 12'd13,   A0, X0, {6'd4, 6'd5, 6'd6, 6'd7, 6'd8},
        {6'd9, 6'd10, 6'd1, 6'd2, 6'd3}, 4, 1'b0);
    run("src10",  4'd5, 12'd10,   A0, X0, A0, X0, 1, 1'b0);
    run("slax_max", 4'd2, 12'd4095, A0, X0, 30'd0, 30'd0, 11, 1'b0);
    run("srb1",   4'd7, 12'd1,    30'd1, 30'd0, 30'd0, 30'h20000000, 2, 1'b0);
    run("slb1",   4'd6, 12'd1,    30'd0, 30'h20000000, 30'd1, 30'd0, 2, 1'b0);
    run("slb_max", 4'd6, 12'd100, A0, X0, 30'd0, 30'd0, 61, 1'b0);
    run("sra_clamp", 4'd1, 12'd7, A0, X0, 30'd0, X0, 6, 1'b0);
    run("m0",     4'd2, 12'd0,    A0, X0, A0, X0, 1, 1'b0);
    run("inval9", 4'd9, 12'd5,    A0, X0, A0, X0, 1, 1'b1);

    // Start while busy must be ignored and not queued.
    @(negedge clk);
    field = 4'd0; m = 12'd2; ina = A0; inx = X0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    field = 4'd3; m = 12'd1; ina = '0; inx = '0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("busy_ignore_count", 64'(n_done), 64'd1);
    chk("busy_ignore_a", 64'(outa), 64'({6'd3, 6'd4, 6'd5, 6'd0, 6'd0}));

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    field = 4'd2; m = 12'd8; ina = A0; inx = X0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midreset", 64'({busy, done, err, outa, outx}), 64'd0);
    @(negedge clk); reset = 1'b0;
    run("after_reset", 4'd0, 12'd2, A0, X0, {6'd3, 6'd4, 6'd5, 6'd0, 6'd0}, X0, 3, 1'b0);

    // Back-to-back: start held high, second op accepted in the done cycle.
    @(negedge clk);
    field = 4'd0; m = 12'd1; ina = A0; inx = X0; start = 1'b1;
    @(posedge clk); #1;
    field = 4'd1; m = 12'd1; ina = X0; inx = A0;
    @(posedge clk); @(posedge clk); #1;
    chk("b2b_first_done", 64'({done, busy}), 64'({1'b1, 1'b0}));
    chk("b2b_first_a", 64'(outa), 64'({6'd2, 6'd3, 6'd4, 6'd5, 6'd0}));
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept", 64'({busy, done}), 64'({1'b1, 1'b0}));
    @(posedge clk); @(posedge clk); #1;
    chk("b2b_second_done", 64'(done), 64'd1);
    chk("b2b_second_ax", 64'(out), 64'({6'd0, 6'd6, 6'd7, 6'd8, 6'd9, A0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
